// File: rtl/debayer_controller.sv
`default_nettype none
// ============================================================================
// Module   : debayer_controller
// Purpose  : Frame sequencer that fetches packed 2x2 Bayer quads and streams
//            one ARGB pixel per quad with its destination address.
// Revision : 1.0 - initial release
// ============================================================================

module debayer (
    input  logic [31:0] i_quad,
    output logic [31:0] o_pixel
);
    logic [8:0] w_green_sum;

    // The sum needs nine bits so that bright greens average without wrapping.
    assign w_green_sum = {1'b0, i_quad[23:16]} + {1'b0, i_quad[15:8]};
    assign o_pixel     = {8'hFF, i_quad[31:24], w_green_sum[8:1], i_quad[7:0]};
endmodule

module debayer_controller #(
    parameter int QUADS_X = 320,
    parameter int QUADS_Y = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [31:0]       px_data,
    output logic [ADDR_W-1:0] px_addr,
    output logic              busy,
    output logic              done
);
    localparam int                c_total = QUADS_X * QUADS_Y;
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(c_total - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PUSH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [31:0]       r_quad;
    logic [31:0]       w_pixel;

    debayer u_debayer (
        .i_quad  (r_quad),
        .o_pixel (w_pixel)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_quad  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_FETCH;
                        r_src   <= src_base;
                        r_dst   <= dst_base;
                        r_idx   <= '0;
                    end
                end
                S_FETCH: begin
                    r_state <= abort ? S_IDLE : S_LATCH;
                end
                S_LATCH: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_quad  <= rd_data;
                        r_state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // Abort beats a coincident final handshake: no done pulse.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (px_ready) begin
                        if (r_idx == c_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure state decodes so they clear the instant reset asserts.
    assign rd_en    = (r_state == S_FETCH);
    assign rd_addr  = rd_en ? (r_src + r_idx) : '0;
    assign px_valid = (r_state == S_PUSH);
    assign px_data  = px_valid ? w_pixel : '0;
    assign px_addr  = px_valid ? (r_dst + r_idx) : '0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
endmodule

`default_nettype wire
